// File: rtl/detect_event_monitor.sv
// Event monitor behind the serial sequence detector: edge-counts the match level, keeps
// lifetime and per-window counts, and raises an acknowledged alarm. Option: DET_TIMESTAMP_EN.
module detect_event_monitor #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TH_W    = 8,
    parameter int unsigned WIN_LEN = 64,
    parameter int unsigned HOLD    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det_in,
    input  logic             en,
    input  logic             clr,
    input  logic             ack,
    input  logic [TH_W-1:0]  thresh,
    output logic [CNT_W-1:0] total_cnt,
    output logic [TH_W-1:0]  win_cnt,
    output logic             alarm,
    output logic             alarm_pulse,
`ifdef DET_TIMESTAMP_EN
    output logic [CNT_W-1:0] last_stamp,
`endif
    output logic [1:0]       state_o
);

    localparam int unsigned TMR_W = $clog2(WIN_LEN);
    localparam int unsigned HLD_W = $clog2(HOLD + 1);
    localparam logic [TMR_W-1:0] TmrLast  = TMR_W'(WIN_LEN - 1);
    localparam logic [HLD_W-1:0] HoldInit = HLD_W'(HOLD);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StArmed = 2'b01,
        StAlert = 2'b10,
        StCool  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [TH_W-1:0]    win_q, win_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [HLD_W-1:0]   hold_q, hold_d;
    logic               alarm_q, alarm_d;
    logic               pulse_q, pulse_d;
    logic               det_prev_q, det_prev_d;

    logic               evt;
    logic               cnt_evt;
    logic [CNT_W-1:0]   total_inc;
    logic [TH_W-1:0]    win_inc;

    assign evt       = det_in & ~det_prev_q;
    assign total_inc = (total_q == '1) ? total_q : total_q + CNT_W'(1);
    assign win_inc   = (win_q == '1) ? win_q : win_q + TH_W'(1);

    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        win_d      = win_q;
        timer_d    = timer_q;
        hold_d     = hold_q;
        alarm_d    = alarm_q;
        pulse_d    = 1'b0;
        det_prev_d = det_in;
        cnt_evt    = 1'b0;

        if (clr) begin
            // Clear discards any event in the same cycle; det_prev still tracks the level.
            total_d = '0;
            win_d   = '0;
            timer_d = '0;
            alarm_d = 1'b0;
            state_d = en ? StArmed : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        state_d = StArmed;
                        timer_d = '0;
                    end
                end
                StArmed: begin
                    if (!en) begin
                        state_d = StIdle;
                    end else begin
                        cnt_evt = evt;
                        if (timer_q == TmrLast) begin
                            // An event on the wrap cycle opens the new window.
                            timer_d = '0;
                            win_d   = evt ? TH_W'(1) : '0;
                        end else begin
                            timer_d = timer_q + TMR_W'(1);
                            if (evt) begin
                                win_d = win_inc;
                            end
                        end
                        // Compare only on an event so a lowered threshold waits for the next one.
                        if (evt && (thresh != '0) && (win_d >= thresh)) begin
                            state_d = StAlert;
                            alarm_d = 1'b1;
                            pulse_d = 1'b1;
                        end
                    end
                end
                StAlert: begin
                    cnt_evt = evt;
                    if (ack) begin
                        alarm_d = 1'b0;
                        hold_d  = HoldInit;
                        state_d = StCool;
                    end
                end
                StCool: begin
                    cnt_evt = evt;
                    hold_d  = hold_q - HLD_W'(1);
                    if (hold_q == HLD_W'(1)) begin
                        win_d   = '0;
                        timer_d = '0;
                        state_d = en ? StArmed : StIdle;
                    end
                end
            endcase

            if (cnt_evt) begin
                total_d = total_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            total_q    <= '0;
            win_q      <= '0;
            timer_q    <= '0;
            hold_q     <= '0;
            alarm_q    <= 1'b0;
            pulse_q    <= 1'b0;
            det_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            win_q      <= win_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
            alarm_q    <= alarm_d;
            pulse_q    <= pulse_d;
            det_prev_q <= det_prev_d;
        end
    end

`ifdef DET_TIMESTAMP_EN
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stamp_q, stamp_d;

    always_comb begin
        cycle_d = cycle_q + CNT_W'(1);
        stamp_d = stamp_q;
        if (clr) begin
            stamp_d = '0;
        end else if (cnt_evt) begin
            stamp_d = cycle_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            stamp_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            stamp_q <= stamp_d;
        end
    end

    assign last_stamp = stamp_q;
`endif

    assign total_cnt   = total_q;
    assign win_cnt     = win_q;
    assign alarm       = alarm_q;
    assign alarm_pulse = pulse_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_detect_event_monitor.sv
// Directed bench for detect_event_monitor: expected outputs are queued per step and
// checked 1 ns after the following clock edge.
module tb_detect_event_monitor;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TH_W    = 8;
    localparam int unsigned WIN_LEN = 64;
    localparam int unsigned HOLD    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             det_in;
    logic             en;
    logic             clr;
    logic             ack;
    logic [TH_W-1:0]  thresh;
    logic [CNT_W-1:0] total_cnt;
    logic [TH_W-1:0]  win_cnt;
    logic             alarm;
    logic             alarm_pulse;
    logic [1:0]       state_o;
`ifdef DET_TIMESTAMP_EN
    logic [CNT_W-1:0] last_stamp;
`endif

    detect_event_monitor #(
        .CNT_W   (CNT_W),
        .TH_W    (TH_W),
        .WIN_LEN (WIN_LEN),
        .HOLD    (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .det_in      (det_in),
        .en          (en),
        .clr         (clr),
        .ack         (ack),
        .thresh      (thresh),
        .total_cnt   (total_cnt),
        .win_cnt     (win_cnt),
        .alarm       (alarm),
        .alarm_pulse (alarm_pulse),
`ifdef DET_TIMESTAMP_EN
        .last_stamp  (last_stamp),
`endif
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    tot;
        int    win;
        int    alm;
        int    pls;
        int    st;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   edges_run   = 0;
    int   exp_stamp   = 0;

    task automatic chk(input string tag, input int got, input int want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        if (!rst) edges_run++;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".total"}, int'(total_cnt), e.tot);
            chk({e.tag, ".win"}, int'(win_cnt), e.win);
            chk({e.tag, ".alarm"}, int'(alarm), e.alm);
            chk({e.tag, ".pulse"}, int'(alarm_pulse), e.pls);
            chk({e.tag, ".state"}, int'(state_o), e.st);
        end
    endtask

    task automatic step(input string tag, input logic d, input int tot, input int win,
                        input int alm, input int pls, input int st);
        exp_t e;
        det_in = d;
        e.tag = tag;
        e.tot = tot;
        e.win = win;
        e.alm = alm;
        e.pls = pls;
        e.st  = st;
        sb.push_back(e);
        cyc();
    endtask

    initial begin
        rst = 1'b1; det_in = 1'b0; en = 1'b0; clr = 1'b0; ack = 1'b0; thresh = '0;

        // Reset for two cycles.
        cyc();
        step("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0; en = 1'b1;
        step("arm", 0, 0, 0, 0, 0, 1);

        // Edge counting: high 5, low 3, high 1, thresh disabled.
        step("t1_rise", 1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("t1_hold", 1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("t1_low", 0, 1, 1, 0, 0, 1);
        step("t1_rise2", 1, 2, 2, 0, 0, 1);
        step("t1_end", 0, 2, 2, 0, 0, 1);

        // Threshold alarm at 3 events, 4 cycles apart.
        clr = 1'b1;
        step("t2_clr", 0, 0, 0, 0, 0, 1);
        clr = 1'b0; thresh = 8'd3;
        step("t2_e1", 1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("t2_gap1", 0, 1, 1, 0, 0, 1);
        step("t2_e2", 1, 2, 2, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("t2_gap2", 0, 2, 2, 0, 0, 1);
        step("t2_e3", 1, 3, 3, 1, 1, 2);
        step("t2_after", 0, 3, 3, 1, 0, 2);
        step("t2_alert_evt", 1, 4, 3, 1, 0, 2);
        en = 1'b0;
        step("t2_alert_en0", 0, 4, 3, 1, 0, 2);
        en = 1'b1;

        // Ack and cooldown; ack in COOL is ignored, events count total only.
        ack = 1'b1;
        step("t4_ack", 0, 4, 3, 0, 0, 3);
        ack = 1'b0;
        step("t4_cool1", 1, 5, 3, 0, 0, 3);
        ack = 1'b1;
        step("t4_cool2", 0, 5, 3, 0, 0, 3);
        ack = 1'b0;
        step("t4_cool3", 1, 6, 3, 0, 0, 3);
        step("t4_exit", 0, 6, 0, 0, 0, 1);

        // Back to ALERT, then clr + ack with a det edge.
        step("t5_e1", 1, 7, 1, 0, 0, 1);
        step("t5_g1", 0, 7, 1, 0, 0, 1);
        step("t5_e2", 1, 8, 2, 0, 0, 1);
        step("t5_g2", 0, 8, 2, 0, 0, 1);
        step("t5_e3", 1, 9, 3, 1, 1, 2);
        step("t5_g3", 0, 9, 3, 1, 0, 2);
        clr = 1'b1; ack = 1'b1;
        step("t5_clr_ack", 1, 0, 0, 0, 0, 1);
        clr = 1'b0; ack = 1'b0;
        step("t5_level", 1, 0, 0, 0, 0, 1);
        step("t5_low", 0, 0, 0, 0, 0, 1);

        // Window wrap: third event lands on the wrap cycle.
        clr = 1'b1;
        step("t3_clr", 0, 0, 0, 0, 0, 1);
        clr = 1'b0;
        step("t3_e1", 1, 1, 1, 0, 0, 1);
        step("t3_g1", 0, 1, 1, 0, 0, 1);
        step("t3_e2", 1, 2, 2, 0, 0, 1);
        for (int i = 4; i < 64; i++) step("t3_idle", 0, 2, 2, 0, 0, 1);
        step("t3_wrap", 1, 3, 1, 0, 0, 1);
        step("t3_after", 0, 3, 1, 0, 0, 1);

        // Saturation of the 4-bit lifetime counter.
        thresh = '0; clr = 1'b1;
        step("t6_clr", 0, 0, 0, 0, 0, 1);
        clr = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            exp_stamp = edges_run % 16;
            step("t6_evt", 1, (i > 15) ? 15 : i, i, 0, 0, 1);
            step("t6_low", 0, (i > 15) ? 15 : i, i, 0, 0, 1);
        end
`ifdef DET_TIMESTAMP_EN
        chk("t6_stamp", int'(last_stamp), exp_stamp);
`endif

        // IDLE does not count; re-enable does not create a false edge.
        en = 1'b0;
        step("idle_enter", 0, 15, 20, 0, 0, 0);
        step("idle_evt", 1, 15, 20, 0, 0, 0);
        en = 1'b1;
        step("idle_rearm", 1, 15, 20, 0, 0, 1);
        step("idle_level", 1, 15, 20, 0, 0, 1);
        step("idle_low", 0, 15, 20, 0, 0, 1);
        step("rearm_evt", 1, 15, 21, 0, 0, 1);
        clr = 1'b1;
        step("final_clr", 0, 0, 0, 0, 0, 1);
        clr = 1'b0;
`ifdef DET_TIMESTAMP_EN
        chk("final_stamp", int'(last_stamp), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/detect_event_monitor.md
Name: detect_event_monitor

Overview:
- Sits directly downstream of the serial sequence-detector FSM and consumes its 1-bit registered match output.
- Turns the raw detect level into counted events:
  - a saturating lifetime count;
  - a per-window count over a fixed number of cycles;
  - a latched alarm when the window count reaches a programmable threshold.
- The alarm is held until acknowledged, followed by a cooldown.

Parameters:
- CNT_W, 16: width of the lifetime event counter.
- TH_W, 8: width of the threshold and of the window counter.
- WIN_LEN, 64: window length in cycles, >= 2.
- HOLD, 4: cooldown length in cycles after ack, >= 1.

Ports:
- clk  in  1  single clock, all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- det_in  in  1  match level from the upstream detector.
- en  in  1  monitor enable.
- clr  in  1  clear counters and timer; one-cycle strobe.
- ack  in  1  alarm acknowledge; one-cycle strobe.
- thresh  in  TH_W  alarm threshold; 0 disables the alarm.
- total_cnt  out  CNT_W  lifetime event count, saturating.
- win_cnt  out  TH_W  events in the current window, saturating.
- alarm  out  1  latched alarm level.
- alarm_pulse  out  1  one-cycle strobe on alarm entry.
- state_o  out  2  current FSM state.

Behaviour:
- Reset (rst=1 at a clk edge) forces the following; rst overrides every other input:
  - total_cnt=0, win_cnt=0, win_timer=0;
  - alarm=0, alarm_pulse=0;
  - det_prev=0, hold_cnt=0;
  - state=IDLE.
- Event definition: evt = det_in & ~det_prev.
  - det_prev is registered every cycle in every state, so re-enabling never creates a false edge.
  - A level held high N cycles counts as one event.
- Encoding: IDLE=2'b00, ARMED=2'b01, ALERT=2'b10, COOL=2'b11. state_o is the registered state.
- Priority (highest first): rst, clr, ack, en, evt/timer.
- IDLE:
  - No counting.
  - If en=1, go to ARMED with win_timer=0.
- ARMED:
  - win_timer increments each cycle. At WIN_LEN-1 it wraps to 0 and win_cnt resets to 0.
  - If evt occurs on the wrap cycle, the event belongs to the new window: win_cnt=1.
  - Otherwise evt increments win_cnt (saturating at all-ones) and total_cnt (saturating at all-ones).
  - If thresh!=0 and the post-update win_cnt >= thresh, go to ALERT next cycle. On that same edge set alarm=1 and alarm_pulse=1.
  - If en=0, go to IDLE. win_cnt is retained.
- ALERT:
  - alarm stays high. alarm_pulse is high only on the entry cycle.
  - total_cnt keeps counting evt; win_cnt and win_timer are frozen.
  - en=0 does not leave ALERT.
  - ack=1: alarm=0, hold_cnt=HOLD, go to COOL.
- COOL:
  - total_cnt keeps counting; win_cnt is frozen.
  - hold_cnt decrements each cycle. At 1, go to ARMED with win_cnt=0 and win_timer=0; go to IDLE instead if en=0.
  - ack is ignored.
- clr=1 in any state:
  - total_cnt=0, win_cnt=0, win_timer=0, alarm=0, alarm_pulse=0;
  - next state is ARMED if en=1, else IDLE.
  - An evt in the same cycle is discarded.
- ack and clr together: clr wins.
- ack outside ALERT: no effect.
- Latency:
  - counter outputs reflect evt one cycle after the det_in rising edge is sampled;
  - alarm rises on the same edge that increments win_cnt to thresh.
- thresh changes take effect on the next compare. Lowering thresh below the current win_cnt fires on the next evt, not immediately.

Optional Feature:
- DET_TIMESTAMP_EN.
- Defined:
  - adds a free-running CNT_W-bit cycle counter (reset 0, wraps) and output port last_stamp (CNT_W, out, reset 0);
  - on every counted evt, last_stamp captures the cycle-counter value of that cycle;
  - clr zeroes last_stamp but not the free-running counter.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset/edge counting: rst 2 cycles, en=1, thresh=0; det_in high for 5 cycles, low 3, high 1 -> total_cnt=2, win_cnt=2, alarm never asserts, state_o=01.
- Threshold alarm: WIN_LEN=64, thresh=3, three det_in rising edges 4 cycles apart -> alarm and alarm_pulse rise with win_cnt=3; alarm_pulse low the next cycle; state_o=10.
- Window wrap: thresh=3, 2 events early in the window, third event on the wrap cycle -> win_cnt=1, no alarm.
- Ack/cooldown: in ALERT pulse ack -> alarm=0, state_o=11 for HOLD=4 cycles, then 01 with win_cnt=0; events during COOL raise total_cnt only.
- Clear priority: in ALERT assert clr and ack together with a det_in edge -> total_cnt=0, win_cnt=0, alarm=0, state_o=01.
- Saturation: CNT_W=4, 20 events with thresh=0 -> total_cnt holds at 15; with DET_TIMESTAMP_EN, last_stamp equals the cycle count of the 20th event modulo 16.
